// File: rtl/pixel_frame_scanner.sv
// pixel_frame_scanner: raster-scan reader for a 2-bit pixel frame store.
// Walks (x, y) in row-major order, drives the store's combinational address,
// registers the returned pixel and presents it on a valid/ready stream with
// start-of-frame and end-of-line markers.
//
// Stream handshake: pix_data, pix_sof and pix_eol are meaningful only while
// pix_valid=1. A beat transfers on a rising edge where pix_valid & pix_ready.
// Once raised, pix_valid stays high and the payload holds until that transfer.
// The output register reloads only when it is empty or being emptied, so
// backpressure never drops or repeats a pixel.
module pixel_frame_scanner #(
    parameter int frame_width  = 640,
    parameter int frame_height = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] mem_x,
    output logic [31:0] mem_y,
    input  logic [1:0]  mem_pix,
    output logic [1:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        busy,
    output logic        frame_done
);

    localparam int XW = (frame_width  > 1) ? $clog2(frame_width)  : 1;
    localparam int YW = (frame_height > 1) ? $clog2(frame_height) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Internal state register, kept as a plain named signal for observation.
    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          load;
    logic          x_last;
    logic          y_last;

    // Output register may take a new pixel when empty or being drained.
    assign load   = !pix_valid || pix_ready;
    assign x_last = (x == XW'(frame_width - 1));
    assign y_last = (y == YW'(frame_height - 1));

    // Addresses are the counter registers themselves, zero-extended.
    assign mem_x = 32'(x);
    assign mem_y = 32'(y);

    // Scan FSM: counters, captured pixel, markers and status, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        x     <= '0;
                        y     <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (load) begin
                        pix_data  <= mem_pix;
                        pix_valid <= 1'b1;
                        pix_sof   <= (x == '0) && (y == '0);
                        pix_eol   <= x_last;
                        // Final coordinate: hold the counters and wait for the
                        // last beat to leave the output register.
                        if (x_last && y_last) begin
                            state <= DRAIN;
                        end else if (x_last) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pix_valid && pix_ready) begin
                        pix_valid  <= 1'b0;
                        pix_sof    <= 1'b0;
                        pix_eol    <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        x          <= '0;
                        y          <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_scanner.sv
// tb_pixel_frame_scanner: checks the raster scanner on a 4x3 frame with a
// store returning (x + y) % 4. A negedge monitor scores accepted beats
// against an expected queue and checks payload stability during stalls.
module tb_pixel_frame_scanner;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        pix_ready;
    logic [31:0] mem_x;
    logic [31:0] mem_y;
    logic [31:0] sum_xy;
    logic [1:0]  mem_pix;
    logic [1:0]  pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_eol;
    logic        busy;
    logic        frame_done;

    // Clock
    always #5 clk = ~clk;

    // Store model: pixel = (x + y) % 4, combinational on the address.
    assign sum_xy  = mem_x + mem_y;
    assign mem_pix = sum_xy[1:0];

    pixel_frame_scanner #(
        .frame_width (W),
        .frame_height(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_x     (mem_x),
        .mem_y     (mem_y),
        .mem_pix   (mem_pix),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int total      = 0;
    int bad        = 0;
    int acc_count  = 0;
    int done_count = 0;

    // Expected beats, packed as {data[1:0], sof, eol}.
    logic [3:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [4:0] held = '0;

    typedef struct {
        logic [1:0] data;
        logic       sof;
        logic       eol;
    } vec_t;

    vec_t       tbl [NPIX];
    logic [1:0] spec_vals [NPIX] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2,
                                     2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    // Reference: pixel i of a frame in row-major order.
    function automatic logic [3:0] model_pix(input int i);
        int px;
        int py;
        px = i % W;
        py = i / W;
        return {2'((px + py) % 4), 1'(px == 0 && py == 0), 1'(px == W - 1)};
    endfunction

    // Monitor / scoreboard, sampled away from the rising edge.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({pix_valid, pix_data, pix_sof, pix_eol}), 32'(held));
            if (pix_valid)
                check("busy_while_valid", 32'(busy), 32'd1);
            if (pix_valid && pix_ready) begin
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pixel", 32'({pix_data, pix_sof, pix_eol}), 32'(e));
                end
                acc_count++;
            end
            if (frame_done) done_count++;
            prev_stall = pix_valid && !pix_ready;
            held       = {pix_valid, pix_data, pix_sof, pix_eol};
        end
    end

    // Driver: one frame. mode 0 = ready high, mode 1 = random ready.
    // extras: spurious starts mid-run and in a stretched drain.
    // chain: raise start in the frame_done cycle and return.
    // skip: start is already high from a chained frame.
    task automatic run_frame(input int mode, input bit use_tbl, input bit extras,
                             input bit chain, input bit skip, input int exp_done_n);
        int acc0;
        int done0;
        int n;
        bit finished;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            if (use_tbl) exp_q.push_back({tbl[i].data, tbl[i].sof, tbl[i].eol});
            else         exp_q.push_back(model_pix(i));
        end
        acc0 = acc_count;
        if (!skip) start = 1'b1;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done0 = done_count;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_after_start", 32'(pix_valid), 32'd0);
        n = 0;
        finished = 1'b0;
        while (!finished && n < 300) begin
            if (mode == 1)                        pix_ready = 1'($urandom_range(0, 1));
            else if (extras && (n == 12 || n == 13)) pix_ready = 1'b0;
            else                                  pix_ready = 1'b1;
            if (extras) start = (n == 5 || n == 12);
            if (n == 1) begin
                check("first_valid", 32'(pix_valid), 32'd1);
                check("first_sof", 32'(pix_sof), 32'd1);
                check("first_data", 32'(pix_data), 32'd0);
            end
            if (frame_done) begin
                finished = 1'b1;
                if (exp_done_n > 0) check("done_cycle", 32'(n), 32'(exp_done_n));
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("frame_done_seen", 32'(finished), 32'd1);
        check("accepted_count", 32'(acc_count - acc0), 32'(NPIX));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        if (chain) begin
            start = 1'b1;
        end else begin
            start     = 1'b0;
            pix_ready = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
            end
            check("done_pulses", 32'(done_count - done0), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(pix_valid), 32'd0);
            check("idle_mem_x", mem_x, 32'd0);
            check("idle_mem_y", mem_y, 32'd0);
        end
    endtask

    initial begin
        int acc0;
        int k;
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            tbl[i].data = spec_vals[i];
            tbl[i].sof  = (i == 0);
            tbl[i].eol  = (i == 3 || i == 7 || i == 11);
        end

        // Reset state and idle behaviour.
        #3;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            check("idle_valid", 32'(pix_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(frame_done), 32'd0);
            check("idle_mem_x", mem_x, 32'd0);
            check("idle_mem_y", mem_y, 32'd0);
            @(posedge clk); #1;
        end

        // Full-rate frame against the hand-written table.
        run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, 13);

        // Random backpressure against the reference model.
        repeat (3) run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Starts during RUN and during a stretched DRAIN are discarded.
        run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, 15);

        // Start in the frame_done cycle launches a second frame.
        run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, 13);
        run_frame(0, 1'b1, 1'b0, 1'b0, 1'b1, 13);

        // Asynchronous reset mid-frame, then a clean restart.
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(model_pix(i));
        acc0      = acc_count;
        pix_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while ((acc_count - acc0) < 6 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("reached_pixel7", 32'(acc_count - acc0), 32'd6);
        check("pixel7_valid", 32'(pix_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(pix_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(frame_done), 32'd0);
        check("async_data", 32'(pix_data), 32'd0);
        check("async_sof", 32'(pix_sof), 32'd0);
        check("async_eol", 32'(pix_eol), 32'd0);
        check("async_mem_x", mem_x, 32'd0);
        check("async_mem_y", mem_y, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_scanner.md
# pixel_frame_scanner

Raster-scan reader for the 2-bit pixel frame store. On a start pulse it walks every (x, y) coordinate in row-major order, drives the store's combinational column/row address inputs, registers the returned 2-bit pixel, and emits it on a valid/ready stream with start-of-frame and end-of-line markers. It sits between the pixel store and downstream frame-generation logic, and absorbs downstream backpressure without dropping or repeating pixels.

## Interface
Parameters:
- frame_width, 640, pixels per line; must be ≥ 2.
- frame_height, 480, lines per frame; must be ≥ 1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to scan one frame; ignored while busy=1.
- mem_x  output  32  column address to the store's width input.
- mem_y  output  32  row address to the store's height input.
- mem_pix  input  2  pixel returned combinationally by the store for (mem_x, mem_y).
- pix_data  output  2  registered pixel value.
- pix_valid  output  1  pix_data, pix_sof and pix_eol are valid.
- pix_ready  input  1  downstream accepts the pixel when pix_valid & pix_ready.
- pix_sof  output  1  pixel is (0,0).
- pix_eol  output  1  pixel is the last column of its line.
- busy  output  1  high from the cycle after start is accepted until frame_done.
- frame_done  output  1  one-cycle pulse after the final pixel is accepted.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: mem_x=mem_y=0, pix_valid=0, busy=0. If start=1, go to RUN with x=y=0.
- Load condition: load = !pix_valid | pix_ready.
- RUN, on load:
  - pix_data ← mem_pix.
  - pix_valid ← 1.
  - pix_sof ← (x==0 & y==0).
  - pix_eol ← (x==frame_width-1).
  - Then advance the counters: x+1, wrapping to 0 with y+1 at frame_width-1.
  - On the final coordinate (frame_width-1, frame_height-1), the counters do not advance. Go to DRAIN.
- RUN, not load: all outputs and counters hold, so pix_data stays stable while stalled.
- DRAIN: when pix_valid & pix_ready, clear pix_valid, pix_sof and pix_eol. Pulse frame_done, go to IDLE.
- mem_x and mem_y are the counter registers, zero-extended to 32 bits.
- Each coordinate is sampled exactly once per frame, in row-major order. The count of accepted pixels is exactly frame_width*frame_height.
- A start asserted in RUN or DRAIN is discarded, not queued.
- A start asserted in the frame_done cycle is accepted, because the FSM is already in IDLE.
- Reset (any time, including mid-frame) clears everything immediately:
  - State goes to IDLE and counters go to 0.
  - pix_data, pix_valid, pix_sof, pix_eol, busy and frame_done all go to 0.
  - The partial frame is abandoned.

## Timing
- Start accepted at edge k. Then:
  - busy=1 after edge k.
  - The first pixel (0,0) is captured at edge k+1, so pix_valid=1 after k+1.
- With pix_ready held at 1:
  - One pixel is accepted per cycle.
  - The last pixel is captured at edge k+W*H, where W=frame_width and H=frame_height.
  - It is accepted at edge k+W*H+1. frame_done and busy=0 follow that edge.
  - Total scan occupancy is W*H+1 cycles.
- Address-to-data path is combinational from the counters, through the store, into pix_data. There is no pipeline bubble.
- Backpressure: when pix_ready=0 with pix_valid=1, every output holds until acceptance. A pixel is neither dropped nor duplicated.
- All outputs are registered except mem_x and mem_y, which are register outputs with no logic after them.

## Test plan
Bench settings: frame_width=4, frame_height=3. The bench store model returns mem_pix=(mem_x+mem_y)%4.

- Reset then idle, start=0 for 10 cycles -> pix_valid=0, busy=0, frame_done=0, mem_x=mem_y=0.
- Pulse start with pix_ready=1 throughout:
  - 12 pixels are accepted on consecutive cycles: 0,1,2,3,1,2,3,0,2,3,0,1.
  - pix_sof is set only on the first pixel.
  - pix_eol is set on pixels 4, 8 and 12.
  - frame_done pulses once, 13 cycles after the start edge.
- Toggle pix_ready randomly (50%) -> the same 12-value sequence with the same sof/eol positions. pix_data is stable during every stall. frame_done comes exactly once.
- Pulse start again at pixel 5, and also during DRAIN -> both are ignored. Exactly 12 pixels and one frame_done result.
- Assert start in the frame_done cycle -> a second frame begins. Its first pixel (value 0, sof=1) is valid on the next cycle.
- Assert rst_n=0 asynchronously mid-frame at pixel 7, release, then pulse start:
  - All outputs clear without waiting for a clock edge.
  - The new frame restarts at (0,0) with the full 12-pixel sequence.
